fifo_noc2nic: RTL and testbench

Receive-side flit buffer between the router output link and the NIC's WB master interface; the mirror of `fifo_nic2noc`. It stores incoming flits in one FIFO per virtual channel and tracks complete packets per VC. It returns one credit per flit consumed and a free pulse when a packet's last flit leaves. The WB master interface drains whole packets by VC index.

---
 rtl/fifo_noc2nic_pkg.sv | 26 ++
 rtl/vc_buffer.sv | 71 +++++++
 rtl/fifo_noc2nic.sv | 87 ++++++++
 tb/tb_fifo_noc2nic.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_noc2nic_pkg.sv
// Shared flit field layout and helpers for the NIC receive buffer.
// Flit type codes: head, body, tail, head_tail.
package fifo_noc2nic_pkg;

  localparam int FLIT_WIDTH    = 32;
  localparam int FLIT_TYPE_MSB = 31;
  localparam int FLIT_TYPE_LSB = 30;
  localparam int FLIT_VC_MSB   = 29;
  localparam int FLIT_VC_LSB   = 27;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'b00,
    FT_BODY      = 2'b01,
    FT_TAIL      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_e;

  function automatic logic is_last(
    input logic [FLIT_WIDTH-1:0] f
  );
    flit_type_e ft;
    ft = flit_type_e'(f[FLIT_TYPE_MSB:FLIT_TYPE_LSB]);
    return (ft == FT_TAIL) || (ft == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/vc_buffer.sv
// Single-VC circular flit FIFO with occupancy and complete-packet count.
// A write to a full buffer is taken only when a pop frees a slot that cycle.
module vc_buffer
  import fifo_noc2nic_pkg::*;
#(
  parameter int BUFFER_DEPTH   = 8,
  parameter int N_BITS_POINTER = 3,
  parameter int N_BITS_CREDIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [FLIT_WIDTH-1:0] wr_flit,
  input  logic                  rd_en,
  output logic [FLIT_WIDTH-1:0] head_flit,
  output logic                  empty,
  output logic                  pkt_ready,
  output logic                  popped,
  output logic                  popped_last,
  output logic                  dropped
);

  logic [FLIT_WIDTH-1:0]     mem [BUFFER_DEPTH];
  logic [N_BITS_POINTER-1:0] wr_ptr;
  logic [N_BITS_POINTER-1:0] rd_ptr;
  logic [N_BITS_CREDIT-1:0]  occ;
  logic [N_BITS_CREDIT-1:0]  pkt_cnt;
  logic                      full;
  logic                      do_wr;
  logic                      do_rd;
  logic                      wr_last;

  assign empty       = (occ == '0);
  assign full        = (occ == N_BITS_CREDIT'(BUFFER_DEPTH));
  assign do_rd       = rd_en && !empty;
  assign do_wr       = wr_en && (!full || do_rd);
  assign dropped     = wr_en && !do_wr;
  assign head_flit   = mem[rd_ptr];
  assign wr_last     = do_wr && is_last(wr_flit);
  assign popped      = do_rd;
  assign popped_last = do_rd && is_last(head_flit);
  assign pkt_ready   = (pkt_cnt != '0);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_flit;
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      pkt_cnt <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_wr && !do_rd: occ <= occ + 1'b1;
        do_rd && !do_wr: occ <= occ - 1'b1;
        default: ;
      endcase
      unique case (1'b1)
        wr_last && !popped_last: pkt_cnt <= pkt_cnt + 1'b1;
        popped_last && !wr_last: pkt_cnt <= pkt_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_noc2nic.sv
// Router-to-NIC flit buffer: per-VC FIFOs, read mux,
// registered credit/free pulses and a sticky overflow flag.
module fifo_noc2nic
  import fifo_noc2nic_pkg::*;
#(
  parameter int N_TOT_OF_VC    = 6,
  parameter int N_BITS_VC_ID   = 3,
  parameter int BUFFER_DEPTH   = 8,
  parameter int N_BITS_POINTER = 3,
  parameter int N_BITS_CREDIT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FLIT_WIDTH-1:0]   in_link_i,
  input  logic                    is_valid_i,
  output logic [N_TOT_OF_VC-1:0]  credit_signal_o,
  output logic [N_TOT_OF_VC-1:0]  free_signal_o,
  output logic [N_TOT_OF_VC-1:0]  packet_ready_o,
  input  logic [N_BITS_VC_ID-1:0] rd_vc_id_i,
  input  logic                    rd_en_i,
  output logic [FLIT_WIDTH-1:0]   rd_flit_o,
  output logic                    rd_empty_o,
  output logic                    overflow_o
);

  logic [N_BITS_VC_ID-1:0] wr_vc;
  logic                    wr_vc_ok;
  logic                    rd_vc_ok;
  logic [N_TOT_OF_VC-1:0]  wr_en;
  logic [N_TOT_OF_VC-1:0]  rd_en;
  logic [N_TOT_OF_VC-1:0]  empty;
  logic [N_TOT_OF_VC-1:0]  popped;
  logic [N_TOT_OF_VC-1:0]  popped_last;
  logic [N_TOT_OF_VC-1:0]  dropped;
  logic [FLIT_WIDTH-1:0]   head [N_TOT_OF_VC];

  assign wr_vc    = N_BITS_VC_ID'(in_link_i[FLIT_VC_MSB:FLIT_VC_LSB]);
  assign wr_vc_ok = 32'(wr_vc) < N_TOT_OF_VC;
  assign rd_vc_ok = 32'(rd_vc_id_i) < N_TOT_OF_VC;

  for (genvar i = 0; i < N_TOT_OF_VC; i++) begin : g_vc
    assign wr_en[i] = is_valid_i && wr_vc_ok &&
                      (wr_vc == N_BITS_VC_ID'(i));
    assign rd_en[i] = rd_en_i && (rd_vc_id_i == N_BITS_VC_ID'(i));

    vc_buffer #(
      .BUFFER_DEPTH  (BUFFER_DEPTH),
      .N_BITS_POINTER(N_BITS_POINTER),
      .N_BITS_CREDIT (N_BITS_CREDIT)
    ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en[i]),
      .wr_flit    (in_link_i),
      .rd_en      (rd_en[i]),
      .head_flit  (head[i]),
      .empty      (empty[i]),
      .pkt_ready  (packet_ready_o[i]),
      .popped     (popped[i]),
      .popped_last(popped_last[i]),
      .dropped    (dropped[i])
    );
  end

  always_comb begin
    rd_empty_o = 1'b1;
    rd_flit_o  = '0;
    if (rd_vc_ok) begin
      rd_empty_o = empty[rd_vc_id_i];
      if (!empty[rd_vc_id_i]) rd_flit_o = head[rd_vc_id_i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_signal_o <= '0;
      free_signal_o   <= '0;
      overflow_o      <= 1'b0;
    end else begin
      credit_signal_o <= popped;
      free_signal_o   <= popped_last;
      if ((|dropped) || (is_valid_i && !wr_vc_ok))
        overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_noc2nic.sv
// Self-checking bench: table vectors, corner sequences and random
// traffic against a per-VC queue model.
module tb_fifo_noc2nic;
  import fifo_noc2nic_pkg::*;

  localparam int NV    = 6;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_link;
  logic        is_valid;
  logic [5:0]  credit;
  logic [5:0]  free;
  logic [5:0]  pr;
  logic [2:0]  rd_vc;
  logic        rd_en;
  logic [31:0] rd_flit;
  logic        rd_empty;
  logic        ovf;

  always #5 clk = ~clk;

  fifo_noc2nic dut (
    .clk            (clk),
    .rst            (rst),
    .in_link_i      (in_link),
    .is_valid_i     (is_valid),
    .credit_signal_o(credit),
    .free_signal_o  (free),
    .packet_ready_o (pr),
    .rd_vc_id_i     (rd_vc),
    .rd_en_i        (rd_en),
    .rd_flit_o      (rd_flit),
    .rd_empty_o     (rd_empty),
    .overflow_o     (ovf)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] q [NV][$];
  logic        m_ovf;
  logic [5:0]  m_cr;
  logic [5:0]  m_fr;

  typedef struct {
    logic       v;
    logic [1:0] t;
    logic [2:0] vc;
    logic       re;
    logic [2:0] rv;
    logic [5:0] pr;
    logic [5:0] cr;
    logic [5:0] fr;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [1:0] t,
                                     input logic [2:0] vc,
                                     input logic [26:0] pl);
    return {t, vc, pl};
  endfunction

  // A VC is ready when its queue holds any tail or head_tail flit.
  function automatic logic [5:0] m_ready();
    logic [5:0] r = '0;
    for (int i = 0; i < NV; i++)
      foreach (q[i][k]) if (q[i][k][31]) r[i] = 1'b1;
    return r;
  endfunction

  task automatic check_model();
    chk("ready", pr, m_ready());
    chk("credit", credit, m_cr);
    chk("free", free, m_fr);
    chk("overflow", ovf, m_ovf);
    if (rd_vc < NV && q[rd_vc].size() > 0) begin
      chk("empty", rd_empty, 0);
      chk("flit", rd_flit, q[rd_vc][0]);
    end else begin
      chk("empty", rd_empty, 1);
      chk("flit", rd_flit, 0);
    end
  endtask

  task automatic model_step(input logic v, input logic [31:0] f,
                            input logic re, input logic [2:0] rv);
    int vc;
    m_cr = '0;
    m_fr = '0;
    if (re && rv < NV && q[rv].size() > 0) begin
      m_cr[rv] = 1'b1;
      m_fr[rv] = q[rv][0][31];
      void'(q[rv].pop_front());
    end
    if (v) begin
      vc = int'(f[29:27]);
      if (vc >= NV) m_ovf = 1'b1;
      else if (q[vc].size() < DEPTH) q[vc].push_back(f);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic cycle(input logic v, input logic [31:0] f,
                       input logic re, input logic [2:0] rv);
    @(negedge clk);
    is_valid = v;
    in_link  = f;
    rd_en    = re;
    rd_vc    = rv;
    @(posedge clk);
    model_step(v, f, re, rv);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic re, input logic [2:0] rv);
    @(negedge clk);
    rst      = 1'b1;
    is_valid = 1'b0;
    in_link  = '0;
    rd_en    = re;
    rd_vc    = rv;
    @(posedge clk);
    for (int i = 0; i < NV; i++) q[i].delete();
    m_ovf = 1'b0;
    m_cr  = '0;
    m_fr  = '0;
    #1;
    check_model();
    @(negedge clk);
    rst   = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    is_valid = 1'b0;
    in_link  = '0;
    rd_en    = 1'b0;
    rd_vc    = '0;
    m_ovf    = 1'b0;
    m_cr     = '0;
    m_fr     = '0;

    tbl[0]  = '{1'b1, 2'b00, 3'd2, 1'b0, 3'd2, 6'h00, 6'h00, 6'h00};
    tbl[1]  = '{1'b1, 2'b01, 3'd2, 1'b0, 3'd2, 6'h00, 6'h00, 6'h00};
    tbl[2]  = '{1'b1, 2'b10, 3'd2, 1'b0, 3'd2, 6'h04, 6'h00, 6'h00};
    tbl[3]  = '{1'b0, 2'b00, 3'd0, 1'b1, 3'd2, 6'h04, 6'h04, 6'h00};
    tbl[4]  = '{1'b0, 2'b00, 3'd0, 1'b1, 3'd2, 6'h04, 6'h04, 6'h00};
    tbl[5]  = '{1'b0, 2'b00, 3'd0, 1'b1, 3'd2, 6'h00, 6'h04, 6'h04};
    tbl[6]  = '{1'b0, 2'b00, 3'd0, 1'b0, 3'd2, 6'h00, 6'h00, 6'h00};
    tbl[7]  = '{1'b1, 2'b11, 3'd0, 1'b0, 3'd0, 6'h01, 6'h00, 6'h00};
    tbl[8]  = '{1'b1, 2'b11, 3'd5, 1'b0, 3'd0, 6'h21, 6'h00, 6'h00};
    tbl[9]  = '{1'b0, 2'b00, 3'd0, 1'b1, 3'd5, 6'h01, 6'h20, 6'h20};
    tbl[10] = '{1'b0, 2'b00, 3'd0, 1'b0, 3'd0, 6'h01, 6'h00, 6'h00};

    // reset and idle, sweeping the read selector
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b0, 3'(i));

    // table vectors
    do_reset(1'b0, 3'd0);
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].v, mk(tbl[i].t, tbl[i].vc, 27'(i + 100)),
            tbl[i].re, tbl[i].rv);
      chk($sformatf("tbl%0d_ready", i), pr, tbl[i].pr);
      chk($sformatf("tbl%0d_credit", i), credit, tbl[i].cr);
      chk($sformatf("tbl%0d_free", i), free, tbl[i].fr);
    end

    // full VC, 9th write without pop
    do_reset(1'b0, 3'd1);
    for (int k = 0; k < DEPTH; k++)
      cycle(1'b1, mk(2'b01, 3'd1, 27'(k + 1)), 1'b0, 3'd1);
    cycle(1'b1, mk(2'b10, 3'd1, 27'd99), 1'b0, 3'd1);
    chk("ovf_set", ovf, 1);
    cycle(1'b0, '0, 1'b0, 3'd1);
    cycle(1'b0, '0, 1'b0, 3'd1);
    chk("ovf_sticky", ovf, 1);
    for (int k = 0; k < DEPTH + 1; k++) cycle(1'b0, '0, 1'b1, 3'd1);
    chk("ovf_drained_empty", rd_empty, 1);
    chk("ovf_no_tail_kept", pr, 0);

    // full VC, 9th write with a pop in the same cycle
    do_reset(1'b0, 3'd1);
    for (int k = 0; k < DEPTH; k++)
      cycle(1'b1, mk(2'b01, 3'd1, 27'(k + 1)), 1'b0, 3'd1);
    cycle(1'b1, mk(2'b10, 3'd1, 27'd9), 1'b1, 3'd1);
    chk("full_wr_pop_ovf", ovf, 0);
    chk("full_wr_pop_credit", credit, 6'h02);
    chk("full_wr_pop_head", rd_flit, mk(2'b01, 3'd1, 27'd2));
    for (int k = 0; k < DEPTH; k++) cycle(1'b0, '0, 1'b1, 3'd1);
    chk("wrap_last_free", free, 6'h02);

    // write and pop same VC at occupancy 4, then pop empty VC 4
    do_reset(1'b0, 3'd3);
    for (int k = 0; k < 4; k++)
      cycle(1'b1, mk(2'b01, 3'd3, 27'(k + 40)), 1'b0, 3'd3);
    cycle(1'b1, mk(2'b10, 3'd3, 27'd44), 1'b1, 3'd3);
    chk("wp_credit", credit, 6'h08);
    for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 3'd3);
    chk("wp_tail_free", free, 6'h08);
    cycle(1'b0, '0, 1'b1, 3'd3);
    chk("wp_empty_after4", rd_empty, 1);
    cycle(1'b0, '0, 1'b1, 3'd4);
    chk("pop_empty_credit", credit, 0);

    // reset mid-packet with a pop pending
    do_reset(1'b0, 3'd1);
    cycle(1'b1, mk(2'b00, 3'd1, 27'd1), 1'b0, 3'd1);
    cycle(1'b1, mk(2'b01, 3'd1, 27'd2), 1'b0, 3'd1);
    cycle(1'b1, mk(2'b10, 3'd1, 27'd3), 1'b0, 3'd1);
    do_reset(1'b1, 3'd1);
    chk("rst_credit", credit, 0);
    chk("rst_free", free, 0);
    chk("rst_empty", rd_empty, 1);

    // random traffic
    for (int r = 0; r < 2000; r++) begin
      logic       v;
      logic [2:0] vc;
      logic       re;
      logic [2:0] rv;
      if (r % 250 == 0) do_reset(1'b0, 3'd0);
      v  = 1'($urandom_range(0, 1));
      vc = ($urandom_range(0, 63) == 0) ? 3'(6 + $urandom_range(0, 1))
                                        : 3'($urandom_range(0, 5));
      re = ($urandom_range(0, 2) != 0);
      rv = 3'($urandom_range(0, 6));
      cycle(v, mk(2'($urandom), vc, 27'($urandom)), re, rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
